// File: rtl/match_sequencer.sv
// Match-level sequencer: serve, rally, post-point pause and match end.
// Build option SEQ_DEUCE_EN: win needs a two-point lead (31 always wins).
module match_sequencer #(
  parameter int WIN_SCORE   = 11,
  parameter int AUTO_DELAY  = 120,
  parameter int PAUSE_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] mode,
  input  logic       serve_type,
  input  logic       serve,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic [4:0] p1_score,
  input  logic [4:0] p2_score,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_side,
  output logic       score_clr,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [7:0] AUTO_T  = 8'(AUTO_DELAY);
  localparam logic [7:0] PAUSE_T = 8'(PAUSE_TICKS);
  localparam logic [5:0] WIN     = 6'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       serve_q;
  logic       serve_rise;
  logic [7:0] timer_q;
  logic       first_q;
  logic       last_pt_q;
  logic       side_q, side_d;
  logic       winner_q, win_d;
  logic [1:0] mode_q;
  logic       new_match;
  logic       p1_win, p2_win;
  logic [5:0] s1, s2;
  logic       timer_run;

  assign serve_rise = serve & ~serve_q;
  assign s1 = {1'b0, p1_score};
  assign s2 = {1'b0, p2_score};

`ifdef SEQ_DEUCE_EN
  // score 31 forces a win so the 5-bit counters never wrap
  assign p1_win = (p1_score == 5'd31) ||
                  ((s1 >= WIN) && (s1 >= s2 + 6'd2));
  assign p2_win = (p2_score == 5'd31) ||
                  ((s2 >= WIN) && (s2 >= s1 + 6'd2));
`else
  assign p1_win = (s1 >= WIN);
  assign p2_win = (s2 >= WIN);
`endif

  always_comb begin
    state_d   = state_q;
    score_clr = 1'b0;
    ball_run  = 1'b0;
    game_over = 1'b0;
    new_match = 1'b0;
    side_d    = side_q;
    win_d     = winner_q;
    unique case (state_q)
      IDLE: begin
        if (serve_rise) begin
          state_d   = SERVE;
          score_clr = 1'b1;
          new_match = 1'b1;
        end
      end
      SERVE: begin
        if (serve_type ? serve_rise : (timer_q >= AUTO_T))
          state_d = RALLY;
      end
      RALLY: begin
        ball_run = 1'b1;
        if (point_p1 | point_p2)
          state_d = POINT;
      end
      POINT: begin
        if (timer_q >= PAUSE_T) begin
          if (mode_q == 2'b11) begin
            state_d = SERVE;
          end else if (p1_win) begin
            state_d = OVER;
            win_d   = 1'b0;
          end else if (p2_win) begin
            state_d = OVER;
            win_d   = 1'b1;
          end else begin
            state_d = SERVE;
            side_d  = mode_q[1] ? ~side_q : ~last_pt_q;
          end
        end
      end
      OVER: begin
        game_over = 1'b1;
        if (serve_rise) begin
          state_d   = SERVE;
          score_clr = 1'b1;
          new_match = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_match)
      side_d = 1'b0;
  end

  assign timer_run = frame_tick && (timer_q != 8'hff) &&
                     ((state_q == POINT) ||
                      ((state_q == SERVE) && !serve_type));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      serve_q   <= 1'b1;
      timer_q   <= 8'd0;
      first_q   <= 1'b0;
      last_pt_q <= 1'b0;
      side_q    <= 1'b0;
      winner_q  <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      serve_q  <= serve;
      side_q   <= side_d;
      winner_q <= win_d;
      first_q  <= (state_d == SERVE) && (state_q != SERVE);
      if (new_match)
        mode_q <= mode;
      if ((state_q == RALLY) && (point_p1 | point_p2))
        last_pt_q <= ~point_p1;
      if (state_d != state_q)
        timer_q <= 8'd0;
      else if (timer_run)
        timer_q <= timer_q + 8'd1;
    end
  end

  assign ball_load  = first_q;
  assign serve_side = side_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Match-level FSM that sequences the ball/score datapath. It gates ball motion, requests ball reload for each serve, and inserts the post-point pause. It chooses the serving side, detects match end, and clears scores for a new match. It sits between the front-panel serve/mode switches and the game controller's ball-run and score logic.

Parameters:
WIN_SCORE, 11, points needed to win a match (1..31).
AUTO_DELAY, 120, frame ticks from serve-ready to automatic launch (1..255).
PAUSE_TICKS, 60, frame ticks ball is frozen after a point (1..255).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame; all timers count these
mode  in  2  00 tennis, 01 soccer, 10 squash, 11 practice
serve_type  in  1  0 auto, 1 manual
serve  in  1  serve button, level, already debounced
point_p1  in  1  one-cycle pulse: player 1 scored
point_p2  in  1  one-cycle pulse: player 2 scored
p1_score  in  5  current player 1 score from datapath
p2_score  in  5  current player 2 score from datapath
ball_run  out  1  1 = ball may move
ball_load  out  1  one-cycle pulse: place ball at serve position of serve_side
serve_side  out  1  0 = player 1 serves, 1 = player 2 serves
score_clr  out  1  one-cycle pulse: zero both scores
game_over  out  1  match finished
winner  out  1  0 = player 1, 1 = player 2; valid while game_over=1
state  out  3  current state encoding, for debug/display

Behaviour:
- All state updates on posedge clk. When rst=0 at a clock edge the block enters IDLE. Reset values: ball_run=0, ball_load=0, serve_side=0, score_clr=0, game_over=0, winner=0, state=0. A reset mid-operation aborts the match immediately with no pulses.
- serve is edge-detected. serve_rise = serve & ~serve_q, where serve_q resets to 1 so a held button is not treated as a press.
- States and encodings: IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4. Encodings 5-7 are illegal and go to IDLE.
- IDLE: ball_run=0.
  - serve_rise -> SERVE.
  - On the exit cycle: score_clr=1, mode latched into mode_q, serve_side=0.
- SERVE: ball_run=0.
  - ball_load=1 in the first cycle of the state only.
  - Timer is cleared on entry.
  - Auto (serve_type=0): timer increments on frame_tick; at AUTO_DELAY -> RALLY.
  - Manual (serve_type=1): serve_rise -> RALLY. The serve_rise that caused entry is not reused.
  - serve_type is sampled every cycle; a switch mid-wait takes effect immediately and the timer keeps its value.
- RALLY: ball_run=1.
  - point_p1 or point_p2 -> POINT, with ball_run=0 from the next cycle.
  - Simultaneous point_p1 and point_p2: point_p1 wins, point_p2 is ignored.
  - The scorer is recorded in last_pt (0 = p1, 1 = p2).
- POINT: ball_run=0. Timer is cleared on entry and counts frame_tick; at PAUSE_TICKS the exit decision is made from p1_score/p2_score.
  - mode_q=11 (practice): never ends, go to SERVE.
  - Otherwise, if the win condition holds for a player -> OVER with winner set to that player.
  - Otherwise -> SERVE, with serve_side updated by mode_q:
    - 00/01 (tennis/soccer): serve_side = ~last_pt (conceding player serves).
    - 10 (squash): serve_side toggles.
  - Point pulses arriving in POINT, SERVE, IDLE or OVER are ignored.
- OVER: game_over=1, ball_run=0, winner held.
  - serve_rise -> SERVE, with score_clr=1, game_over=0, serve_side=0, and mode re-latched.
- mode changes outside IDLE/OVER exits are ignored until the next latch.
- Timer is 8 bits and saturates; it never wraps.

Optional Feature:
SEQ_DEUCE_EN.
- Defined: a player wins when their score >= WIN_SCORE and leads by >= 2. If either score reaches 31, that player wins regardless of lead, which prevents 5-bit score wrap.
- Undefined: the first player whose score >= WIN_SCORE wins. If both qualify in the same decision, player 1 wins.

Test Plan:
1. Reset hold then release, serve pulse, serve_type=0 -> score_clr pulse on IDLE exit; ball_load in first SERVE cycle; ball_run=1 exactly after 120 frame_ticks.
2. Manual serve: serve held high through IDLE exit -> stays in SERVE until serve is released and pressed again, then RALLY.
3. RALLY with point_p1 and point_p2 in the same cycle, mode 00 -> POINT; after 60 ticks SERVE with serve_side=1; no ball_run during pause.
4. p1_score driven to 11, p2_score=5, point_p1 in RALLY -> OVER, game_over=1, winner=0. Then serve press -> score_clr, SERVE, game_over=0.
5. SEQ_DEUCE_EN defined, scores 11/10 after point -> SERVE, not OVER. Scores 12/10 -> OVER with winner=0. Mode 11 with score 31/0 -> never OVER.
6. rst low during RALLY (ball_run=1) -> next edge state=0, all outputs 0; point pulses are then ignored.
